// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe.
//   in_valid/in_ready/instr/imm_src : producer side (instr carries instruction bits [31:7])
//   out_valid/out_ready/imm_ext/out_illegal : consumer side
//   illegal_cnt : saturating count of accepted illegal entries
// Modports: slave = the immediate block, master = the surrounding environment
// (producer and consumer together).
interface imm_extend_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      instr;
  logic [2:0]       imm_src;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_ext;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output in_valid, instr, imm_src, out_ready,
    input  in_ready, out_valid, imm_ext, out_illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, instr, imm_src, out_ready,
    output in_ready, out_valid, imm_ext, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate extractor/extender with a two-entry (OUT + SKID) elastic output buffer.
// Decodes the RISC-V I/S/B/U/J immediate formats (and optionally the CSR zimm)
// combinationally from the offered instruction, then buffers the result so the
// producer sees a registered in_ready and the consumer sees stable data.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : imm_extend_pipe_if.slave (handshakes, instr, imm_src, imm_ext, out_illegal,
//           illegal_cnt)
// Optional feature: define IMM_EXTEND_ZIMM_EN to decode imm_src 3'b101 as the
// zero-extended CSR zimm; otherwise 3'b101 is treated as illegal.
module imm_extend_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_extend_pipe_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_extend_pipe: XLEN must be 32 or 64");
  end

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;
  localparam logic [2:0] SRC_Z = 3'b101;

  // Indexed as the full instruction so field slices read like the ISA manual.
  logic [31:7]     w_ins;
  logic [31:0]     w_imm32;
  logic            w_sext;
  logic            w_ill;
  logic [XLEN-1:0] w_imm;
  logic            w_acc;
  logic            w_pop;

  logic [1:0]       r_state;
  logic             r_rdy;      // low during reset, high from the first edge after release
  logic [XLEN-1:0]  r_out_imm;
  logic             r_out_ill;
  logic [XLEN-1:0]  r_skid_imm;
  logic             r_skid_ill;
  logic [CNT_W-1:0] r_cnt;

  assign w_ins = bus.instr;

  always_comb begin
    w_imm32 = '0;
    w_sext  = 1'b1;
    w_ill   = 1'b0;
    unique case (bus.imm_src)
      SRC_I: w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
      SRC_S: w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
      SRC_B: w_imm32 = {{20{w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
      SRC_U: w_imm32 = {w_ins[31:12], 12'b0};
      SRC_J: w_imm32 = {{12{w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
`ifdef IMM_EXTEND_ZIMM_EN
      SRC_Z: begin
        w_imm32 = {27'b0, w_ins[19:15]};
        w_sext  = 1'b0;
      end
`else
      SRC_Z: w_ill = 1'b1;
`endif
      default: w_ill = 1'b1;
    endcase
  end

  // All signed formats already carry the sign in bit 31; widen from there.
  assign w_imm = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);

  assign bus.in_ready    = r_rdy && (r_state != ST_TWO);
  assign bus.out_valid   = (r_state != ST_EMPTY);
  assign bus.imm_ext     = r_out_imm;
  assign bus.out_illegal = r_out_ill;
  assign bus.illegal_cnt = r_cnt;

  assign w_acc = bus.in_valid && bus.in_ready;
  assign w_pop = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_rdy      <= 1'b0;
      r_out_imm  <= '0;
      r_out_ill  <= 1'b0;
      r_skid_imm <= '0;
      r_skid_ill <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_rdy <= 1'b1;
      if (w_acc && w_ill && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      unique case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_out_imm <= w_imm;
            r_out_ill <= w_ill;
            r_state   <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && !w_pop) begin
            r_skid_imm <= w_imm;
            r_skid_ill <= w_ill;
            r_state    <= ST_TWO;
          end else if (w_acc && w_pop) begin
            r_out_imm <= w_imm;
            r_out_ill <= w_ill;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the consumer can move the buffer.
          if (w_pop) begin
            r_out_imm <= r_skid_imm;
            r_out_ill <= r_skid_ill;
            r_state   <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_extend_pipe_if #(.XLEN(32), .CNT_W(2)) bus32 ();
  imm_extend_pipe_if #(.XLEN(64), .CNT_W(8)) bus64 ();

  imm_extend_pipe #(.XLEN(32), .CNT_W(2)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  imm_extend_pipe #(.XLEN(64), .CNT_W(8)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  // Both instances see the same stream.
  assign bus64.in_valid  = bus32.in_valid;
  assign bus64.instr     = bus32.instr;
  assign bus64.imm_src   = bus32.imm_src;
  assign bus64.out_ready = bus32.out_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] instr32;
  logic [2:0]  src;

  // Reference model: FIFO of {illegal, imm64} with capacity 2.
  logic [64:0] q[$];
  bit          m_rdy = 1'b0;
  int          m_cnt2 = 0;
  int          m_cnt8 = 0;

  function automatic logic [64:0] ref_entry(input logic [31:0] ins, input logic [2:0] s);
    longint sx = longint'($signed(ins));
    longint v = 0;
    case (s)
      3'd0: v = sx >>> 20;
      3'd1: v = ((sx >>> 25) <<< 5) + longint'(ins[11:7]);
      3'd2: begin
        if (ins[31]) v = -4096;
        v += longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      end
      3'd3: v = (sx >>> 12) <<< 12;
      3'd4: begin
        if (ins[31]) v = -1048576;
        v += longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
             + longint'(ins[30:21]) * 2;
      end
`ifdef IMM_EXTEND_ZIMM_EN
      3'd5: v = longint'(ins[19:15]);
`endif
      default: return {1'b1, 64'd0};
    endcase
    return {1'b0, v};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] s);
    bus32.in_valid = v;
    instr32 = ins;
    src = s;
    bus32.instr = ins[31:7];
    bus32.imm_src = s;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic clk_step(output bit acc);
    bit pop;
    logic [64:0] e;
    acc = bus32.in_valid && m_rdy && (q.size() < 2);
    pop = bus32.out_ready && (q.size() > 0);
    e = ref_entry(instr32, src);
    @(posedge clk);
    if (pop) q.delete(0);
    if (acc) begin
      q.push_back(e);
      if (e[64]) begin
        if (m_cnt2 < 3) m_cnt2++;
        if (m_cnt8 < 255) m_cnt8++;
      end
    end
    m_rdy = rst_n;
    #1;
  endtask

  task automatic test_reset;
    bit a;
    drive(1'b1, 32'h0010_0093, 3'd0);
    bus32.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus32.in_ready !== 1'b0) begin errors++;
      $display("FAIL rst_in_ready32: got %b want 0", bus32.in_ready); end
    checks++; if (bus64.in_ready !== 1'b0) begin errors++;
      $display("FAIL rst_in_ready64: got %b want 0", bus64.in_ready); end
    checks++; if (bus32.out_valid !== 1'b0) begin errors++;
      $display("FAIL rst_out_valid32: got %b want 0", bus32.out_valid); end
    checks++; if (bus32.imm_ext !== 32'd0) begin errors++;
      $display("FAIL rst_imm32: got %h want 0", bus32.imm_ext); end
    checks++; if (bus64.imm_ext !== 64'd0) begin errors++;
      $display("FAIL rst_imm64: got %h want 0", bus64.imm_ext); end
    checks++; if (bus32.out_illegal !== 1'b0) begin errors++;
      $display("FAIL rst_illegal32: got %b want 0", bus32.out_illegal); end
    checks++; if (bus32.illegal_cnt !== 2'd0) begin errors++;
      $display("FAIL rst_cnt32: got %0d want 0", bus32.illegal_cnt); end
    checks++; if (bus64.illegal_cnt !== 8'd0) begin errors++;
      $display("FAIL rst_cnt64: got %0d want 0", bus64.illegal_cnt); end
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 3'd0);
    clk_step(a);
    checks++; if (bus32.in_ready !== 1'b1) begin errors++;
      $display("FAIL rel_in_ready32: got %b want 1", bus32.in_ready); end
    checks++; if (bus64.in_ready !== 1'b1) begin errors++;
      $display("FAIL rel_in_ready64: got %b want 1", bus64.in_ready); end
    checks++; if (bus32.out_valid !== 1'b0) begin errors++;
      $display("FAIL rel_out_valid32: got %b want 0", bus32.out_valid); end
  endtask

  task automatic test_illegal;
    bit a;
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    bus32.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, $urandom, 3'b111);
      clk_step(a);
      checks++; if (bus32.out_valid !== 1'b1 || bus32.out_illegal !== 1'b1) begin errors++;
        $display("FAIL ill_flag[%0d]: got v=%b ill=%b want v=1 ill=1", k, bus32.out_valid,
                 bus32.out_illegal); end
      checks++; if (bus32.imm_ext !== 32'd0 || bus64.imm_ext !== 64'd0) begin errors++;
        $display("FAIL ill_imm[%0d]: got %h/%h want 0", k, bus32.imm_ext, bus64.imm_ext); end
      checks++; if (bus32.illegal_cnt !== exp_cnt[k]) begin errors++;
        $display("FAIL ill_cnt2[%0d]: got %0d want %0d", k, bus32.illegal_cnt, exp_cnt[k]); end
      checks++; if (bus64.illegal_cnt !== 8'(k + 1)) begin errors++;
        $display("FAIL ill_cnt8[%0d]: got %0d want %0d", k, bus64.illegal_cnt, k + 1); end
    end
    drive(1'b0, 32'h0, 3'd0);
    clk_step(a);
  endtask

  task automatic test_formats;
    bit a;
    logic [31:0] ins [4] = '{32'hFFF0_0093, 32'hFE51_2E23, 32'h1234_50B7, 32'h0010_00EF};
    logic [2:0]  fmt [4] = '{3'd0, 3'd1, 3'd3, 3'd4};
    logic [63:0] exp [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC,
                             64'h0000_0000_1234_5000, 64'h0000_0000_0000_0800};
    bus32.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, ins[k], fmt[k]);
      clk_step(a);
      drive(1'b0, 32'h0, 3'd0);
      checks++; if (bus32.out_valid !== 1'b1 || bus32.out_illegal !== 1'b0) begin errors++;
        $display("FAIL fmt_valid[%0d]: got v=%b ill=%b want v=1 ill=0", k, bus32.out_valid,
                 bus32.out_illegal); end
      checks++; if (bus32.imm_ext !== exp[k][31:0]) begin errors++;
        $display("FAIL fmt_imm32[%0d]: got %h want %h", k, bus32.imm_ext, exp[k][31:0]); end
      checks++; if (bus64.imm_ext !== exp[k]) begin errors++;
        $display("FAIL fmt_imm64[%0d]: got %h want %h", k, bus64.imm_ext, exp[k]); end
      clk_step(a);
      checks++; if (bus32.out_valid !== 1'b0) begin errors++;
        $display("FAIL fmt_drain[%0d]: got %b want 0", k, bus32.out_valid); end
    end
  endtask

  task automatic test_zimm;
    bit a;
    bus32.out_ready = 1'b1;
    drive(1'b1, 32'h000F_8000, 3'b101);
    clk_step(a);
    drive(1'b0, 32'h0, 3'd0);
`ifdef IMM_EXTEND_ZIMM_EN
    checks++; if (bus32.imm_ext !== 32'h1F || bus32.out_illegal !== 1'b0) begin errors++;
      $display("FAIL zimm32: got %h ill=%b want 0000001f ill=0", bus32.imm_ext,
               bus32.out_illegal); end
    checks++; if (bus64.imm_ext !== 64'h1F) begin errors++;
      $display("FAIL zimm64: got %h want 1f", bus64.imm_ext); end
`else
    checks++; if (bus32.imm_ext !== 32'h0 || bus32.out_illegal !== 1'b1) begin errors++;
      $display("FAIL zimm32: got %h ill=%b want 0 ill=1", bus32.imm_ext, bus32.out_illegal); end
    checks++; if (bus64.illegal_cnt !== 8'(m_cnt8)) begin errors++;
      $display("FAIL zimm_cnt64: got %0d want %0d", bus64.illegal_cnt, m_cnt8); end
`endif
    clk_step(a);
  endtask

  task automatic test_backpressure;
    bit a;
    logic [31:0] e_ins [3];
    logic [2:0]  e_src [3];
    logic [64:0] e_ref [3];
    for (int k = 0; k < 3; k++) begin
      e_ins[k] = $urandom;
      e_src[k] = 3'($urandom_range(0, 4));
      e_ref[k] = ref_entry(e_ins[k], e_src[k]);
    end
    bus32.out_ready = 1'b0;
    drive(1'b1, e_ins[0], e_src[0]);
    clk_step(a);
    checks++; if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b1) begin errors++;
      $display("FAIL bp_first: got rdy=%b v=%b want 1 1", bus32.in_ready, bus32.out_valid); end
    drive(1'b1, e_ins[1], e_src[1]);
    clk_step(a);
    checks++; if (bus32.in_ready !== 1'b0 || bus64.in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_full: got rdy=%b/%b want 0", bus32.in_ready, bus64.in_ready); end
    drive(1'b1, e_ins[2], e_src[2]);
    clk_step(a);
    checks++; if (bus64.imm_ext !== e_ref[0][63:0] || bus32.in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_hold: got %h rdy=%b want %h rdy=0", bus64.imm_ext, bus32.in_ready,
               e_ref[0][63:0]); end
    bus32.out_ready = 1'b1;
    clk_step(a);
    checks++; if (bus64.imm_ext !== e_ref[1][63:0] || bus32.in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_pop1: got %h rdy=%b want %h rdy=1", bus64.imm_ext, bus32.in_ready,
               e_ref[1][63:0]); end
    clk_step(a);
    drive(1'b0, 32'h0, 3'd0);
    checks++; if (bus32.imm_ext !== e_ref[2][31:0] || bus32.out_valid !== 1'b1) begin errors++;
      $display("FAIL bp_third: got %h v=%b want %h v=1", bus32.imm_ext, bus32.out_valid,
               e_ref[2][31:0]); end
    clk_step(a);
    checks++; if (bus32.out_valid !== 1'b0) begin errors++;
      $display("FAIL bp_empty: got %b want 0", bus32.out_valid); end
  endtask

  task automatic test_random;
    bit a = 1'b1;
    bit exp_rdy;
    for (int n = 0; n < 400; n++) begin
      if (!bus32.in_valid || a) begin
        drive(($urandom % 4) != 0, $urandom, 3'($urandom_range(0, 7)));
      end
      bus32.out_ready = ($urandom % 3) != 0;
      clk_step(a);
      exp_rdy = m_rdy && (q.size() < 2);
      checks++; if (bus32.in_ready !== exp_rdy || bus64.in_ready !== exp_rdy) begin errors++;
        $display("FAIL rnd_in_ready[%0d]: got %b/%b want %b", n, bus32.in_ready,
                 bus64.in_ready, exp_rdy); end
      checks++; if (bus32.out_valid !== (q.size() > 0)) begin errors++;
        $display("FAIL rnd_out_valid[%0d]: got %b want %b", n, bus32.out_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if (bus32.imm_ext !== q[0][31:0] || bus64.imm_ext !== q[0][63:0] ||
            bus32.out_illegal !== q[0][64] || bus64.out_illegal !== q[0][64]) begin
          errors++;
          $display("FAIL rnd_data[%0d]: got %h/%h ill=%b want %h ill=%b", n, bus32.imm_ext,
                   bus64.imm_ext, bus32.out_illegal, q[0][63:0], q[0][64]);
        end
      end
      checks++;
      if (bus32.illegal_cnt !== 2'(m_cnt2) || bus64.illegal_cnt !== 8'(m_cnt8)) begin
        errors++;
        $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", n, bus32.illegal_cnt,
                 bus64.illegal_cnt, m_cnt2, m_cnt8);
      end
    end
    drive(1'b0, 32'h0, 3'd0);
  endtask

  task automatic test_reset_mid;
    bit a;
    bus32.out_ready = 1'b0;
    drive(1'b1, $urandom, 3'b110);
    clk_step(a);
    drive(1'b1, $urandom, 3'b111);
    clk_step(a);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_rdy = 1'b0;
    m_cnt2 = 0;
    m_cnt8 = 0;
    checks++; if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin errors++;
      $display("FAIL mid_out_valid: got %b/%b want 0", bus32.out_valid, bus64.out_valid); end
    checks++; if (bus32.illegal_cnt !== 2'd0 || bus64.illegal_cnt !== 8'd0) begin errors++;
      $display("FAIL mid_cnt: got %0d/%0d want 0", bus32.illegal_cnt, bus64.illegal_cnt); end
    checks++; if (bus32.in_ready !== 1'b0) begin errors++;
      $display("FAIL mid_in_ready: got %b want 0", bus32.in_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 3'd0);
    bus32.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      clk_step(a);
      checks++; if (bus32.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin errors++;
        $display("FAIL mid_stale[%0d]: got %b/%b want 0", k, bus32.out_valid,
                 bus64.out_valid); end
      checks++; if (bus32.in_ready !== 1'b1) begin errors++;
        $display("FAIL mid_ready[%0d]: got %b want 1", k, bus32.in_ready); end
    end
  endtask

  initial begin
    drive(1'b0, 32'h0, 3'd0);
    bus32.out_ready = 1'b0;
    test_reset();
    test_illegal();
    test_formats();
    test_zimm();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
